// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared funct3 encodings, FSM states and lane-mask helper for the
//            load/store alignment unit.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;
    localparam logic [2:0] c_f3_sb  = 3'b000;
    localparam logic [2:0] c_f3_sh  = 3'b001;
    localparam logic [2:0] c_f3_sw  = 3'b010;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    // Byte lanes touched across two consecutive words; size is funct3[1:0].
    function automatic logic [7:0] lane_mask8(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        logic ok;
        if (is_store) begin
            ok = (funct3 == c_f3_sb) || (funct3 == c_f3_sh) || (funct3 == c_f3_sw);
        end else begin
            ok = (funct3 == c_f3_lb) || (funct3 == c_f3_lh) || (funct3 == c_f3_lw) ||
                 (funct3 == c_f3_lbu) || (funct3 == c_f3_lhu);
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_ext.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_ext
// Brief    : Combinational byte extraction and sign/zero extension of load data.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [63:0] i_rvec,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;
    logic        w_unused_hi;

    // Offset never exceeds 3, so the top byte of the two-word vector is never reached.
    assign w_shifted   = i_rvec[{i_off, 3'b000} +: 32];
    assign w_unused_hi = ^i_rvec[63:56];

    always_comb begin
        o_data = '0;
        case (i_funct3)
            c_f3_lb:  o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_f3_lh:  o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            c_f3_lw:  o_data = w_shifted;
            c_f3_lbu: o_data = {24'h0, w_shifted[7:0]};
            c_f3_lhu: o_data = {16'h0, w_shifted[15:0]};
            default:  o_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : RV32 load/store alignment unit driving a word-addressed, byte-masked
//            data memory; splits misaligned accesses into two word beats.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter int MISALIGN_EN = 1,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [2:0]            i_req_funct3,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [31:0]           o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [ADDR_WIDTH-1:0] o_data_addr,
    output logic [31:0]           o_data_wr_data,
    output logic [3:0]            o_data_size,
    output logic                  o_data_write,
    output logic                  o_data_read,
    input  logic [31:0]           i_data_rd_data
);

    localparam logic [ADDR_WIDTH-1:0] c_word_step = ADDR_WIDTH'(4);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_word_addr;
    logic [3:0]            r_mask_hi;
    logic [31:0]           r_wdata_hi;
    logic                  r_write;
    logic [1:0]            r_off;
    logic [2:0]            r_funct3;
    logic [31:0]           r_beat0;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic                  r_rsp_load;
    logic                  r_rsp_split;
    logic [1:0]            r_rsp_off;
    logic [2:0]            r_rsp_funct3;

    logic                  w_accept;
    logic                  w_split_en;
    logic                  w_misaligned;
    logic                  w_err;
    logic [1:0]            w_off;
    logic [7:0]            w_mask;
    logic [63:0]           w_wvec;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic [63:0]           w_rvec;
    logic [31:0]           w_ext;

    generate
        if (MISALIGN_EN != 0) begin : g_split
            assign w_split_en = 1'b1;
        end else begin : g_reject
            assign w_split_en = 1'b0;
        end
    endgenerate

    assign o_req_ready  = (r_state == IDLE) && !i_rst;
    assign w_accept     = i_req_valid && o_req_ready;
    assign w_off        = i_req_addr[1:0];
    assign w_mask       = lane_mask8(i_req_funct3[1:0], w_off);
    assign w_misaligned = |w_mask[7:4];
    assign w_err        = !funct3_legal(i_req_write, i_req_funct3) || (w_misaligned && !w_split_en);
    assign w_wvec       = {32'h0, i_req_wdata} << {w_off, 3'b000};
    assign w_word_addr  = {i_req_addr[ADDR_WIDTH-1:2], 2'b00};

    // Beat1 of a held request takes priority; beat0 goes out in the accept cycle.
    always_comb begin
        o_data_addr    = '0;
        o_data_wr_data = '0;
        o_data_size    = '0;
        o_data_write   = 1'b0;
        o_data_read    = 1'b0;
        if (!i_rst) begin
            if (r_state == SECOND) begin
                o_data_addr    = r_word_addr + c_word_step;
                o_data_wr_data = r_wdata_hi;
                o_data_size    = r_mask_hi;
                o_data_write   = r_write;
                o_data_read    = !r_write;
            end else if (w_accept && !w_err) begin
                o_data_addr    = w_word_addr;
                o_data_wr_data = w_wvec[31:0];
                o_data_size    = w_mask[3:0];
                o_data_write   = i_req_write;
                o_data_read    = !i_req_write;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_word_addr  <= '0;
            r_mask_hi    <= '0;
            r_wdata_hi   <= '0;
            r_write      <= 1'b0;
            r_off        <= '0;
            r_funct3     <= '0;
            r_beat0      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_load   <= 1'b0;
            r_rsp_split  <= 1'b0;
            r_rsp_off    <= '0;
            r_rsp_funct3 <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_load  <= 1'b0;
            r_rsp_split <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rsp_off    <= w_off;
                        r_rsp_funct3 <= i_req_funct3;
                        if (w_err) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else if (w_misaligned) begin
                            r_state     <= SECOND;
                            r_word_addr <= w_word_addr;
                            r_mask_hi   <= w_mask[7:4];
                            r_wdata_hi  <= w_wvec[63:32];
                            r_write     <= i_req_write;
                            r_off       <= w_off;
                            r_funct3    <= i_req_funct3;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_load  <= !i_req_write;
                        end
                    end
                end
                SECOND: begin
                    // The read word arriving now belongs to beat0.
                    r_state      <= IDLE;
                    r_beat0      <= i_data_rd_data;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_split  <= 1'b1;
                    r_rsp_load   <= !r_write;
                    r_rsp_off    <= r_off;
                    r_rsp_funct3 <= r_funct3;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_rvec = r_rsp_split ? {i_data_rd_data, r_beat0} : {32'h0, i_data_rd_data};

    lsu_load_ext u_load_ext (
        .i_rvec   (w_rvec),
        .i_off    (r_rsp_off),
        .i_funct3 (r_rsp_funct3),
        .o_data   (w_ext)
    );

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_rdata = (r_rsp_valid && r_rsp_load) ? w_ext : 32'h0;

endmodule
`default_nettype wire
